// File: rtl/hilo_acc_reg_pkg.sv
// Shared definitions for the HI/LO special-register unit: op encodings,
// accumulate FSM states and the default datapath width.
package hilo_acc_reg_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] HILO_OP_NOP     = 3'd0;
  localparam logic [2:0] HILO_OP_WR_BOTH = 3'd1;
  localparam logic [2:0] HILO_OP_WR_HI   = 3'd2;
  localparam logic [2:0] HILO_OP_WR_LO   = 3'd3;
  localparam logic [2:0] HILO_OP_MADD    = 3'd4;
  localparam logic [2:0] HILO_OP_MSUB    = 3'd5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACC_HI = 1'b1
  } hilo_state_e;

endpackage

// File: rtl/hilo_acc_reg_if.sv
// Request/response bundle between the multiplier side and the HI/LO unit.
interface hilo_acc_reg_if
  import hilo_acc_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              valid;
  logic              ready;
  logic [2:0]        op;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              busy;

  modport master (
    output valid, op, hi_i, lo_i,
    input  ready, hi_o, lo_o, busy
  );

  modport slave (
    input  valid, op, hi_i, lo_i,
    output ready, hi_o, lo_o, busy
  );
endinterface

// File: rtl/hilo_addsub.sv
// Combinational DATA_W-bit add/subtract with carry (add) or borrow (sub)
// in and out; shared by the LO and HI accumulate steps.
module hilo_addsub
  import hilo_acc_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  input  logic              cin,
  output logic [DATA_W-1:0] y,
  output logic              cout
);

  logic [DATA_W:0] sum;

  // In subtract mode the top bit of the widened difference is the borrow-out.
  always_comb begin
    if (sub) sum = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, cin};
    else     sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
  end

  assign y    = sum[DATA_W-1:0];
  assign cout = sum[DATA_W];

endmodule

// File: rtl/hilo_acc_reg.sv
// HI/LO special registers with partial writes and MADD/MSUB accumulate.
// State updates on the falling clock edge so writes are readable mid-cycle.
module hilo_acc_reg
  import hilo_acc_reg_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_SPLIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  hilo_acc_reg_if.slave  bus
);

  hilo_state_e       state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_lat_q, hi_lat_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;

  logic              op_sub;
  logic [DATA_W-1:0] lo_y, hi_y, hi_b;
  logic              lo_cout, hi_cout, hi_cin, hi_sub;

  assign op_sub = (bus.op == HILO_OP_MSUB);

  // Split mode feeds the HI step from the latched operand and saved carry;
  // otherwise the two halves chain into one full-width add in a single edge.
  assign hi_b   = (ACC_SPLIT != 0) ? hi_lat_q : bus.hi_i;
  assign hi_cin = (ACC_SPLIT != 0) ? carry_q  : lo_cout;
  assign hi_sub = (ACC_SPLIT != 0) ? sub_q    : op_sub;

  hilo_addsub #(.DATA_W(DATA_W)) u_lo_addsub (
    .a    (lo_q),
    .b    (bus.lo_i),
    .sub  (op_sub),
    .cin  (1'b0),
    .y    (lo_y),
    .cout (lo_cout)
  );

  hilo_addsub #(.DATA_W(DATA_W)) u_hi_addsub (
    .a    (hi_q),
    .b    (hi_b),
    .sub  (hi_sub),
    .cin  (hi_cin),
    .y    (hi_y),
    .cout (hi_cout)
  );

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_lat_d = hi_lat_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid) begin
          case (bus.op)
            HILO_OP_WR_BOTH: begin
              hi_d = bus.hi_i;
              lo_d = bus.lo_i;
            end
            HILO_OP_WR_HI: hi_d = bus.hi_i;
            HILO_OP_WR_LO: lo_d = bus.lo_i;
            HILO_OP_MADD, HILO_OP_MSUB: begin
              lo_d = lo_y;
              if (ACC_SPLIT != 0) begin
                carry_d  = lo_cout;
                hi_lat_d = bus.hi_i;
                sub_d    = op_sub;
                state_d  = ST_ACC_HI;
              end else begin
                hi_d = hi_y;
              end
            end
            default: ;
          endcase
        end
      end
      ST_ACC_HI: begin
        hi_d    = hi_y;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand latches only matter in ACC_HI, which reset always leaves.
  always_ff @(negedge clk) begin
    hi_lat_q <= hi_lat_d;
    carry_q  <= carry_d;
    sub_q    <= sub_d;
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.busy  = (state_q == ST_ACC_HI);
  assign bus.hi_o  = hi_q;
  assign bus.lo_o  = lo_q;

  logic unused_hi_cout;
  assign unused_hi_cout = hi_cout;

endmodule

// File: tb/tb_hilo_acc_reg.sv
// Directed bench for hilo_acc_reg: one split-accumulate instance and one
// single-step instance, checked after each falling edge.
module tb_hilo_acc_reg;
  import hilo_acc_reg_pkg::*;

  logic clk = 1'b1;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hilo_acc_reg_if #(.DATA_W(32)) bus_a ();
  hilo_acc_reg_if #(.DATA_W(32)) bus_b ();

  hilo_acc_reg #(.DATA_W(32), .ACC_SPLIT(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  hilo_acc_reg #(.DATA_W(32), .ACC_SPLIT(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_a();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [2:0] op, input logic [31:0] hi, input logic [31:0] lo);
    bus_a.valid = v;
    bus_a.op    = op;
    bus_a.hi_i  = hi;
    bus_a.lo_i  = lo;
  endtask

  task automatic drive_b(input logic v, input logic [2:0] op, input logic [31:0] hi, input logic [31:0] lo);
    bus_b.valid = v;
    bus_b.op    = op;
    bus_b.hi_i  = hi;
    bus_b.lo_i  = lo;
  endtask

  task automatic chk_a(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                       input logic rdy, input logic bsy);
    chk({tag, "_hilo"}, {bus_a.hi_o, bus_a.lo_o}, {hi, lo});
    chk({tag, "_rdy_busy"}, {62'd0, bus_a.ready, bus_a.busy}, {62'd0, rdy, bsy});
  endtask

  task automatic chk_b(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                       input logic rdy, input logic bsy);
    chk({tag, "_hilo"}, {bus_b.hi_o, bus_b.lo_o}, {hi, lo});
    chk({tag, "_rdy_busy"}, {62'd0, bus_b.ready, bus_b.busy}, {62'd0, rdy, bsy});
  endtask

  initial begin
    rst = 1'b1;
    drive_a(1'b0, HILO_OP_NOP, 32'h0, 32'h0);
    drive_b(1'b0, HILO_OP_NOP, 32'h0, 32'h0);
    edge_a();
    chk_a("reset_a", 32'h0, 32'h0, 1'b1, 1'b0);
    chk_b("reset_b", 32'h0, 32'h0, 1'b1, 1'b0);
    rst = 1'b0;

    // partial writes
    drive_a(1'b1, HILO_OP_WR_BOTH, 32'h11111111, 32'h22222222);
    edge_a();
    chk_a("wr_both", 32'h11111111, 32'h22222222, 1'b1, 1'b0);
    drive_a(1'b1, HILO_OP_WR_HI, 32'hAAAAAAAA, 32'hDEADBEEF);
    edge_a();
    chk_a("wr_hi", 32'hAAAAAAAA, 32'h22222222, 1'b1, 1'b0);
    drive_a(1'b1, HILO_OP_WR_LO, 32'h12345678, 32'h55555555);
    edge_a();
    chk_a("wr_lo", 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0);
    drive_a(1'b1, HILO_OP_NOP, 32'h01010101, 32'h02020202);
    edge_a();
    chk_a("nop", 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0);
    drive_a(1'b1, 3'd7, 32'h03030303, 32'h04040404);
    edge_a();
    chk_a("op7", 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0);
    drive_a(1'b0, HILO_OP_WR_BOTH, 32'h09090909, 32'h08080808);
    edge_a();
    chk_a("no_valid", 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0);

    // MADD with carry from LO into HI, then held request with changed hi_i
    drive_a(1'b1, HILO_OP_WR_BOTH, 32'h00000000, 32'hFFFFFFFF);
    edge_a();
    drive_a(1'b1, HILO_OP_MADD, 32'h00000000, 32'h00000001);
    edge_a();
    chk_a("madd_lo_step", 32'h0, 32'h0, 1'b0, 1'b1);
    drive_a(1'b1, HILO_OP_MADD, 32'h00000005, 32'h00000001);
    edge_a();
    chk_a("madd_hi_step", 32'h1, 32'h0, 1'b1, 1'b0);
    edge_a();
    chk_a("held_lo_step", 32'h1, 32'h1, 1'b0, 1'b1);
    drive_a(1'b0, HILO_OP_NOP, 32'h0, 32'h0);
    edge_a();
    chk_a("held_hi_step", 32'h6, 32'h1, 1'b1, 1'b0);

    // MSUB borrow and wrap, then MADD back to zero
    drive_a(1'b1, HILO_OP_WR_BOTH, 32'h0, 32'h0);
    edge_a();
    drive_a(1'b1, HILO_OP_MSUB, 32'h0, 32'h1);
    edge_a();
    chk_a("msub_lo_step", 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1);
    drive_a(1'b0, HILO_OP_NOP, 32'h0, 32'h0);
    edge_a();
    chk_a("msub_wrap", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    drive_a(1'b1, HILO_OP_MADD, 32'h0, 32'h1);
    edge_a();
    drive_a(1'b0, HILO_OP_NOP, 32'h0, 32'h0);
    edge_a();
    chk_a("madd_wrap", 32'h0, 32'h0, 1'b1, 1'b0);

    // MSUB with nonzero HI and a borrow
    drive_a(1'b1, HILO_OP_WR_BOTH, 32'h5, 32'h3);
    edge_a();
    drive_a(1'b1, HILO_OP_MSUB, 32'h2, 32'h4);
    edge_a();
    drive_a(1'b0, HILO_OP_NOP, 32'h0, 32'h0);
    edge_a();
    chk_a("msub_borrow", 32'h2, 32'hFFFFFFFF, 1'b1, 1'b0);

    // reset during ACC_HI discards the partial result
    drive_a(1'b1, HILO_OP_WR_BOTH, 32'h7, 32'h9);
    edge_a();
    drive_a(1'b1, HILO_OP_MADD, 32'h1, 32'h1);
    edge_a();
    chk_a("pre_reset", 32'h7, 32'hA, 1'b0, 1'b1);
    rst = 1'b1;
    drive_a(1'b0, HILO_OP_NOP, 32'h0, 32'h0);
    edge_a();
    chk_a("reset_mid_acc", 32'h0, 32'h0, 1'b1, 1'b0);
    edge_a();
    chk_a("reset_hold", 32'h0, 32'h0, 1'b1, 1'b0);
    rst = 1'b0;

    // single-step accumulate instance
    drive_b(1'b1, HILO_OP_WR_BOTH, 32'h0, 32'hFFFFFFFF);
    edge_a();
    drive_b(1'b1, HILO_OP_MADD, 32'h0, 32'h1);
    edge_a();
    chk_b("nosplit_madd", 32'h1, 32'h0, 1'b1, 1'b0);
    drive_b(1'b0, HILO_OP_NOP, 32'h0, 32'h0);
    edge_a();
    chk_b("nosplit_settled", 32'h1, 32'h0, 1'b1, 1'b0);
    drive_b(1'b1, HILO_OP_MSUB, 32'h0, 32'h1);
    edge_a();
    chk_b("nosplit_msub", 32'h0, 32'hFFFFFFFF, 1'b1, 1'b0);
    drive_b(1'b1, HILO_OP_MADD, 32'h00000002, 32'h00000003);
    edge_a();
    chk_b("nosplit_back2back", 32'h3, 32'h2, 1'b1, 1'b0);
    drive_b(1'b0, HILO_OP_NOP, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/hilo_acc_reg.md
Name: hilo_acc_reg

Overview:
Parametrised HI/LO special-register unit for the MIPS datapath. It adds separate HI-only and LO-only writes (MTHI/MTLO) and multiply-accumulate support (MADD/MSUB) with a valid/ready handshake. Accumulate uses an optional two-step carry-split add, which keeps the 2W-bit adder off the critical path. It sits beside the multiplier output; its outputs feed the MFHI/MFLO forwarding mux.

Parameters:
DATA_W, 32, width of each of HI and LO.
ACC_SPLIT, 1, 1 = accumulate takes two steps (LO step, then HI step); 0 = single-step 2*DATA_W add.

Ports:
clk  in  1  clock; all state updates on the falling edge, so a write made in the first half-cycle is readable in the second half.
rst  in  1  synchronous, active-high reset, sampled on the falling edge of clk.
valid  in  1  request present.
ready  out  1  unit can accept a request this cycle.
op  in  3  0 NOP, 1 WR_BOTH, 2 WR_HI, 3 WR_LO, 4 MADD, 5 MSUB; 6 and 7 are treated as NOP.
hi_i  in  DATA_W  HI operand, or upper half of the product.
lo_i  in  DATA_W  LO operand, or lower half of the product.
hi_o  out  DATA_W  current HI.
lo_o  out  DATA_W  current LO.
busy  out  1  accumulate in progress; hi_o/lo_o are not yet coherent.

Behaviour:
- Reset: hi_o=0, lo_o=0, state=IDLE, busy=0, ready=1. Reset overrides everything, including mid-accumulate; the partial result is discarded.
- A request is accepted at a falling edge when valid && ready. Requests are ignored when ready=0. The source must hold valid/op/operands until accepted.
- ready = (state==IDLE). busy = (state==ACC_HI).
- WR_BOTH: hi_o<=hi_i, lo_o<=lo_i at the accepting edge.
- WR_HI: update hi_o only; lo_o is unchanged.
- WR_LO: update lo_o only; hi_o is unchanged.
- NOP/6/7: no state change. Still accepted, so they consume the handshake.
- All write ops have latency 1 edge and keep state=IDLE.
- MADD: {hi,lo} <= {hi,lo} + {hi_i,lo_i}. MSUB: {hi,lo} <= {hi,lo} - {hi_i,lo_i}.
  - Arithmetic is modulo 2^(2*DATA_W).
  - No overflow flag and no trap.
  - Signed/unsigned variants are identical here; sign-correct products are the multiplier's job.
- ACC_SPLIT=0: the full 2W result is written at the accepting edge; state stays IDLE.
- ACC_SPLIT=1, FSM states IDLE and ACC_HI:
  - IDLE, accepting edge with MADD/MSUB:
    - lo_o <= lo_o ± lo_i.
    - Save carry-out (add) or borrow-out (sub) into a 1-bit register.
    - Latch hi_i and the op sign.
    - Go to ACC_HI.
  - ACC_HI, next edge:
    - hi_o <= hi_o + hi_i_latched + carry (add), or hi_o - hi_i_latched - borrow (sub).
    - Go to IDLE.
  - ACC_HI always lasts exactly one cycle; there is no stall input.
  - lo_o shows the final LO while busy=1; hi_o shows the old HI until the ACC_HI edge.
- Back-to-back: with ACC_SPLIT=1, the earliest next acceptance is the edge after ACC_HI, so MADD throughput is 1 per 2 cycles. Writes are 1 per cycle.
- Operand changes while busy have no effect, because hi_i was latched.

Decomposition:
- Shared package (mips_defines): HILO_OP_* encodings (3-bit), the FSM state encoding (IDLE=0, ACC_HI=1), and DATA_W default 32.
- One natural sub-module: hilo_addsub. It is a combinational DATA_W-bit add/sub with carry/borrow in and out, and is reused for the LO and HI steps.
- The FSM and registers stay in hilo_acc_reg.

Test Plan:
1. Reset then idle: assert rst for 2 cycles mid-operation -> hi_o=0, lo_o=0, ready=1, busy=0 after the first falling edge with rst=1.
2. Partial writes: WR_BOTH hi=0x11111111, lo=0x22222222; then WR_HI hi_i=0xAAAAAAAA; then WR_LO lo_i=0x55555555 -> final hi_o=0xAAAAAAAA, lo_o=0x55555555; each update is visible after one edge.
3. MADD carry across halves (ACC_SPLIT=1): start {0x00000000,0xFFFFFFFF}, MADD {0x00000000,0x00000001}:
   - first edge: lo_o=0, busy=1, ready=0, hi_o=0.
   - second edge: hi_o=1, busy=0.
4. MSUB borrow and wrap: start {0,0}, MSUB {0,1} -> {0xFFFFFFFF,0xFFFFFFFF}. Then MADD {0,1} -> {0,0}.
5. Handshake hold: hold valid with MADD on the cycle busy=1, with a changed hi_i -> not accepted during ACC_HI; it is accepted on the following edge, and only the latched hi_i affects the first result.
6. Reset mid-accumulate plus mode check: rst during ACC_HI -> {0,0}, state IDLE. Repeat scenario 3 with ACC_SPLIT=0 -> {1,0} after a single edge, busy never 1.
